// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C master and slave blocks.
//   i2c_state_e  - protocol state encoding (slave uses all of it; the master
//                  reuses the enumerators whose names coincide)
//   I2C_ACK/NACK - value of SDA during the acknowledge bit
//   I2C_AW       - bus address width
package i2c_pkg;

  localparam int   I2C_AW   = 7;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: 2-flop synchronizer plus registered edge detector for one
// asynchronous bus line.
//   clk, reset - system clock, async active-high reset
//   in         - raw bus line
//   level      - synchronized level, time-aligned with rise/fall
//   rise, fall - one-cycle pulses, 3 clk after the pin changes
// RST_VAL is the idle bus level so no edge is seen on reset release.
module i2c_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= RST_VAL;
      s2    <= RST_VAL;
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= in;
      s2    <= s1;
      level <= s2;
      rise  <= s2 & ~level;
      fall  <= ~s2 & level;
    end
  end

endmodule

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C slave fronting an 8-bit register file.
//   clk, reset      - system clock (>= 8x SCL), async active-high reset
//   scl, sda        - I2C bus; sda is open-drain (drives only 0 or z)
//   rd_addr/rd_data - combinational application read port
//   wr_strobe       - one-cycle pulse per register written from the bus,
//                     with wr_addr/wr_data holding the last write
//   busy            - high from an address match until STOP
// Write transactions: first byte is the register pointer, later bytes are
// stored at ptr with auto-increment. Reads stream regs[ptr] with increment on
// each master ACK. The pointer persists across transactions.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [I2C_AW-1:0] SLAVE_ADDR = 7'h42,
  parameter int                NUM_REGS   = 16,
  localparam int               PW         = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl,
  inout  wire           sda,
  input  logic [PW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  logic scl_l, scl_rise, scl_fall;
  logic sda_l, sda_rise, sda_fall;
  logic start, stop;

  i2c_sync_edge #(.RST_VAL(1'b1)) u_scl_sync (
    .clk(clk), .reset(reset), .in(scl),
    .level(scl_l), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.RST_VAL(1'b1)) u_sda_sync (
    .clk(clk), .reset(reset), .in(sda),
    .level(sda_l), .rise(sda_rise), .fall(sda_fall)
  );

  assign start = sda_fall & scl_l;
  assign stop  = sda_rise & scl_l;

  i2c_state_e    state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [PW-1:0] ptr, ptr_n;
  logic          sda_oe, sda_oe_n;
  logic          busy_n;
  logic          rw, rw_n;
  logic          first_byte, first_byte_n;
  logic          reg_we;
  logic [7:0]    rx_byte, cur_byte;
  logic [7:0]    regs [NUM_REGS];

  assign sda      = sda_oe ? 1'b0 : 1'bz;
  assign rx_byte  = {shreg[6:0], sda_l};
  assign cur_byte = regs[ptr];
  assign rd_data  = regs[rd_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      ptr        <= '0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      rw         <= 1'b0;
      first_byte <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      ptr        <= ptr_n;
      sda_oe     <= sda_oe_n;
      busy       <= busy_n;
      rw         <= rw_n;
      first_byte <= first_byte_n;
      wr_strobe  <= reg_we;
      if (reg_we) begin
        wr_addr <= ptr;
        wr_data <= rx_byte;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[ptr] <= rx_byte;
    end
  end

  // ACK states use sda_oe as their phase: the first SCL fall after the byte
  // starts driving the ACK, the second one ends it.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    ptr_n        = ptr;
    sda_oe_n     = sda_oe;
    busy_n       = busy;
    rw_n         = rw;
    first_byte_n = first_byte;
    reg_we       = 1'b0;

    if (stop) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (shreg[I2C_AW-1:0] == SLAVE_ADDR) begin
              state_n      = ADDR_ACK;
              rw_n         = sda_l;
              busy_n       = 1'b1;
              first_byte_n = 1'b1;
            end else begin
              state_n = IGNORE;
            end
          end
        end

        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_n = 1'b1;
          end else begin
            bit_cnt_n = '0;
            if (state == ADDR_ACK && rw) begin
              // first read bit goes out on the same fall that ends the ACK
              state_n  = RD_BYTE;
              sda_oe_n = ~cur_byte[7];
              shreg_n  = {cur_byte[6:0], 1'b0};
            end else begin
              state_n  = WR_BYTE;
              sda_oe_n = 1'b0;
            end
          end
        end

        WR_BYTE: if (scl_rise) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = WR_ACK;
            if (first_byte) begin
              ptr_n        = rx_byte[PW-1:0];
              first_byte_n = 1'b0;
            end else begin
              reg_we = 1'b1;
              ptr_n  = ptr + PW'(1);
            end
          end
        end

        RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = RD_ACK;
          end else if (scl_fall) begin
            // bit_cnt==0 here only after a master ACK: fetch the next byte
            if (bit_cnt == 3'd0) begin
              sda_oe_n = ~cur_byte[7];
              shreg_n  = {cur_byte[6:0], 1'b0};
            end else begin
              sda_oe_n = ~shreg[7];
              shreg_n  = {shreg[6:0], 1'b0};
            end
          end
        end

        RD_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
          end else if (scl_rise) begin
            if (sda_l == I2C_ACK) begin
              ptr_n     = ptr + PW'(1);
              bit_cnt_n = '0;
              state_n   = RD_BYTE;
            end else begin
              state_n = IGNORE;
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: bit-banged I2C master driving i2c_slave_regs, checked
// against a transaction-level model (register array, pointer, write queue).
module tb_i2c_slave_regs;

  localparam int         NR = 16;
  localparam int         PW = 4;
  localparam logic [6:0] SA = 7'h42;
  localparam int         Q  = 8;   // clk per SCL quarter
  localparam int         H  = 4;   // SDA hold after SCL fall

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          scl = 1'b1;
  logic          m_low = 1'b0;
  wire           sda;
  logic [PW-1:0] rd_addr = '0;
  logic [7:0]    rd_data, wr_data;
  logic [PW-1:0] wr_addr;
  logic          wr_strobe, busy;

  int          vec = 0;
  int          miscomp = 0;
  logic [7:0]  mregs [NR];
  int          mptr;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  bit          slave_low_seen = 0;
  bit          busy_seen = 0;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_regs #(.SLAVE_ADDR(SA), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy)
  );

  // bus monitor, sampled between the active edge and the stimulus edge
  always begin
    @(posedge clk); #2;
    if (wr_strobe === 1'b1) got_q.push_back({8'(wr_addr), wr_data});
    if (sda === 1'b0 && !m_low) slave_low_seen = 1;
    if (busy === 1'b1) busy_seen = 1;
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_bit_w(input logic b);
    m_low = ~b; wclk(Q); scl = 1'b1; wclk(2*Q); scl = 1'b0; wclk(H);
  endtask

  task automatic m_bit_r(output logic b);
    m_low = 1'b0; wclk(Q); scl = 1'b1; wclk(Q); b = sda; wclk(Q); scl = 1'b0; wclk(H);
  endtask

  task automatic m_start;
    m_low = 1'b0; wclk(Q); scl = 1'b1; wclk(Q); m_low = 1'b1; wclk(Q); scl = 1'b0; wclk(H);
  endtask

  task automatic m_stop;
    m_low = 1'b1; wclk(Q); scl = 1'b1; wclk(Q); m_low = 1'b0; wclk(Q);
  endtask

  // ack output: 1 when the slave acknowledged
  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) m_bit_w(d[i]);
    m_bit_r(a);
    ack = (a == 1'b0);
  endtask

  task automatic m_rbyte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin m_bit_r(b); d[i] = b; end
    m_bit_w(~ack);
  endtask

  task automatic test_reset;
    reset = 1'b1; wclk(4);
    vec++; if (sda !== 1'b1) begin miscomp++; $display("FAIL rst_sda got=%b exp=1", sda); end
    vec++; if (busy !== 1'b0) begin miscomp++; $display("FAIL rst_busy got=%b exp=0", busy); end
    vec++; if (wr_strobe !== 1'b0) begin miscomp++; $display("FAIL rst_strobe got=%b exp=0", wr_strobe); end
    vec++; if (wr_addr !== '0) begin miscomp++; $display("FAIL rst_wr_addr got=%0h exp=0", wr_addr); end
    vec++; if (wr_data !== 8'h00) begin miscomp++; $display("FAIL rst_wr_data got=%0h exp=0", wr_data); end
    for (int i = 0; i < NR; i++) begin
      rd_addr = PW'(i); #1;
      vec++; if (rd_data !== 8'h00) begin miscomp++; $display("FAIL rst_reg%0d got=%0h exp=0", i, rd_data); end
    end
    reset = 1'b0; wclk(4);
    for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
    mptr = 0;
  endtask

  task automatic test_single_write;
    logic a0, a1, a2;
    got_q.delete();
    m_start; m_wbyte({SA, 1'b0}, a0); m_wbyte(8'h03, a1); m_wbyte(8'hA5, a2); m_stop;
    mregs[3] = 8'hA5; mptr = 4;
    vec++; if ({a0, a1, a2} !== 3'b111) begin miscomp++; $display("FAIL sw_acks got=%b exp=111", {a0, a1, a2}); end
    vec++; if (got_q.size() != 1) begin miscomp++; $display("FAIL sw_strobe_cnt got=%0d exp=1", got_q.size()); end
    else begin
      vec++; if (got_q[0] !== 16'h03A5) begin miscomp++; $display("FAIL sw_strobe got=%h exp=03a5", got_q[0]); end
    end
    rd_addr = 4'd3; #1;
    vec++; if (rd_data !== 8'hA5) begin miscomp++; $display("FAIL sw_reg3 got=%h exp=a5", rd_data); end
  endtask

  task automatic test_mismatch;
    logic a0, a1, a2;
    got_q.delete(); slave_low_seen = 0; busy_seen = 0;
    m_start; m_wbyte({7'h43, 1'b0}, a0); m_wbyte(8'($urandom), a1); m_wbyte(8'($urandom), a2); m_stop;
    vec++; if ({a0, a1, a2} !== 3'b000) begin miscomp++; $display("FAIL mm_acks got=%b exp=000", {a0, a1, a2}); end
    vec++; if (slave_low_seen) begin miscomp++; $display("FAIL mm_sda_low got=1 exp=0"); end
    vec++; if (busy_seen) begin miscomp++; $display("FAIL mm_busy got=1 exp=0"); end
    vec++; if (got_q.size() != 0) begin miscomp++; $display("FAIL mm_strobe_cnt got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_burst_wrap;
    logic a0, a1, a2, a3;
    got_q.delete();
    m_start; m_wbyte({SA, 1'b0}, a0); m_wbyte(8'h0F, a1); m_wbyte(8'h11, a2); m_wbyte(8'h22, a3); m_stop;
    mregs[15] = 8'h11; mregs[0] = 8'h22; mptr = 1;
    vec++; if ({a0, a1, a2, a3} !== 4'hF) begin miscomp++; $display("FAIL bw_acks got=%b exp=1111", {a0, a1, a2, a3}); end
    vec++; if (got_q.size() != 2) begin miscomp++; $display("FAIL bw_strobe_cnt got=%0d exp=2", got_q.size()); end
    else begin
      vec++; if (got_q[0] !== 16'h0F11 || got_q[1] !== 16'h0022) begin
        miscomp++; $display("FAIL bw_strobes got=%h,%h exp=0f11,0022", got_q[0], got_q[1]); end
    end
    rd_addr = 4'd15; #1;
    vec++; if (rd_data !== 8'h11) begin miscomp++; $display("FAIL bw_reg15 got=%h exp=11", rd_data); end
    rd_addr = 4'd0; #1;
    vec++; if (rd_data !== 8'h22) begin miscomp++; $display("FAIL bw_reg0 got=%h exp=22", rd_data); end
  endtask

  task automatic test_combined_read;
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    m_start; m_wbyte({SA, 1'b0}, a0); m_wbyte(8'h03, a1);
    m_start; m_wbyte({SA, 1'b1}, a2);
    mptr = 3;
    m_rbyte(1'b1, d0);
    vec++; if (d0 !== mregs[3]) begin miscomp++; $display("FAIL cr_byte0 got=%h exp=%h", d0, mregs[3]); end
    mptr = 4;
    m_rbyte(1'b0, d1);
    vec++; if (d1 !== mregs[4]) begin miscomp++; $display("FAIL cr_byte1 got=%h exp=%h", d1, mregs[4]); end
    vec++; if ({a0, a1, a2} !== 3'b111) begin miscomp++; $display("FAIL cr_acks got=%b exp=111", {a0, a1, a2}); end
    slave_low_seen = 0; wclk(2*Q);
    vec++; if (slave_low_seen) begin miscomp++; $display("FAIL cr_release got=low exp=released"); end
    vec++; if (busy !== 1'b1) begin miscomp++; $display("FAIL cr_busy got=%b exp=1", busy); end
    m_stop;
    vec++; if (busy !== 1'b0) begin miscomp++; $display("FAIL cr_busy_stop got=%b exp=0", busy); end
  endtask

  task automatic test_stop_mid_byte;
    logic a0, a1, a2;
    logic [7:0] d;
    got_q.delete();
    m_start; m_wbyte({SA, 1'b0}, a0); m_wbyte(8'h06, a1); mptr = 6;
    for (int i = 0; i < 5; i++) m_bit_w(1'($urandom));
    m_stop;
    vec++; if ({a0, a1} !== 2'b11) begin miscomp++; $display("FAIL smb_acks got=%b exp=11", {a0, a1}); end
    vec++; if (got_q.size() != 0) begin miscomp++; $display("FAIL smb_strobe_cnt got=%0d exp=0", got_q.size()); end
    vec++; if (busy !== 1'b0) begin miscomp++; $display("FAIL smb_busy got=%b exp=0", busy); end
    rd_addr = 4'd6; #1;
    vec++; if (rd_data !== mregs[6]) begin miscomp++; $display("FAIL smb_reg6 got=%h exp=%h", rd_data, mregs[6]); end
    m_start; m_wbyte({SA, 1'b1}, a2); m_rbyte(1'b0, d); m_stop;
    vec++; if (a2 !== 1'b1 || d !== mregs[mptr]) begin
      miscomp++; $display("FAIL smb_readback got=%b/%h exp=1/%h", a2, d, mregs[mptr]); end
  endtask

  task automatic test_reset_mid_read;
    logic a0, a1, a2, b;
    logic [7:0] d0, d1;
    m_start; m_wbyte({SA, 1'b0}, a0); m_wbyte(8'h08, a1); m_wbyte(8'hF0, a2); m_stop;
    mregs[8] = 8'hF0;
    m_start; m_wbyte({SA, 1'b0}, a0); m_wbyte(8'h08, a1);
    m_start; m_wbyte({SA, 1'b1}, a2);
    for (int i = 0; i < 4; i++) m_bit_r(b);
    wclk(2);
    vec++; if (sda !== mregs[8][3]) begin miscomp++; $display("FAIL rmr_bit4 got=%b exp=%b", sda, mregs[8][3]); end
    reset = 1'b1; #1;
    vec++; if (sda !== 1'b1) begin miscomp++; $display("FAIL rmr_sda_rel got=%b exp=1", sda); end
    vec++; if (busy !== 1'b0) begin miscomp++; $display("FAIL rmr_busy got=%b exp=0", busy); end
    scl = 1'b1; m_low = 1'b0; wclk(4); reset = 1'b0; wclk(4);
    for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
    mptr = 0;
    rd_addr = 4'd8; #1;
    vec++; if (rd_data !== 8'h00) begin miscomp++; $display("FAIL rmr_reg8 got=%h exp=00", rd_data); end
    m_start; m_wbyte({SA, 1'b1}, a0); m_rbyte(1'b1, d0); m_rbyte(1'b0, d1); m_stop;
    vec++; if (a0 !== 1'b1 || d0 !== mregs[0] || d1 !== mregs[1]) begin
      miscomp++; $display("FAIL rmr_after got=%b/%h/%h exp=1/%h/%h", a0, d0, d1, mregs[0], mregs[1]); end
    mptr = 1;
  endtask

  task automatic test_random;
    logic       ack, match, last;
    logic [6:0] a;
    logic [7:0] p, d;
    int         kind, n, idx;
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        match = ($urandom_range(0, 3) != 0);
        a = match ? SA : (SA ^ 7'($urandom_range(1, 127)));
        got_q.delete(); exp_q.delete();
        m_start; m_wbyte({a, 1'b0}, ack);
        vec++; if (ack !== match) begin miscomp++; $display("FAIL rnd_addr_ack t=%0d got=%b exp=%b", t, ack, match); end
        p = 8'($urandom);
        m_wbyte(p, ack);
        vec++; if (ack !== match) begin miscomp++; $display("FAIL rnd_ptr_ack t=%0d got=%b exp=%b", t, ack, match); end
        if (match) mptr = p % NR;
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          m_wbyte(d, ack);
          vec++; if (ack !== match) begin miscomp++; $display("FAIL rnd_data_ack t=%0d got=%b exp=%b", t, ack, match); end
          if (match) begin
            mregs[mptr] = d;
            exp_q.push_back({8'(mptr), d});
            mptr = (mptr + 1) % NR;
          end
        end
        m_stop;
        vec++; if (got_q.size() != exp_q.size()) begin
          miscomp++; $display("FAIL rnd_strobe_cnt t=%0d got=%0d exp=%0d", t, got_q.size(), exp_q.size()); end
        else begin
          for (int k = 0; k < exp_q.size(); k++) begin
            vec++; if (got_q[k] !== exp_q[k]) begin
              miscomp++; $display("FAIL rnd_strobe t=%0d got=%h exp=%h", t, got_q[k], exp_q[k]); end
          end
        end
      end else if (kind == 1) begin
        if ($urandom_range(0, 1) == 1) begin
          m_start; m_wbyte({SA, 1'b0}, ack);
          p = 8'($urandom);
          m_wbyte(p, ack);
          mptr = p % NR;
        end
        m_start; m_wbyte({SA, 1'b1}, ack);
        vec++; if (ack !== 1'b1) begin miscomp++; $display("FAIL rnd_rd_ack t=%0d got=%b exp=1", t, ack); end
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          last = (k == n - 1);
          m_rbyte(~last, d);
          vec++; if (d !== mregs[mptr]) begin
            miscomp++; $display("FAIL rnd_rd t=%0d ptr=%0d got=%h exp=%h", t, mptr, d, mregs[mptr]); end
          if (!last) mptr = (mptr + 1) % NR;
        end
        m_stop;
      end else begin
        idx = $urandom_range(0, NR - 1);
        rd_addr = PW'(idx); #1;
        vec++; if (rd_data !== mregs[idx]) begin
          miscomp++; $display("FAIL rnd_side idx=%0d got=%h exp=%h", idx, rd_data, mregs[idx]); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_mismatch;
    test_burst_wrap;
    test_combined_read;
    test_stop_mid_byte;
    test_reset_mid_read;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

I2C slave with an internal 8-bit register file. It is the bus-side consumer of `i2c_master` in the same design: it watches SCL/SDA, ACKs its own address, accepts a register pointer and data bytes on writes, and returns register contents on reads. The application reads the register file through a side port and is notified of every bus write.

## Interface
- `SLAVE_ADDR`, default 7'h42: 7-bit address this slave answers to.
- `NUM_REGS`, default 16: register count; power of two, 2..256.
- `clk  in  1`: system clock, shared with the master. Must be at least 8× the SCL frequency.
- `reset  in  1`: reset, asynchronous, active-high.
- `scl  in  1`: bus clock; asynchronous to `clk`.
- `sda  inout  1`: bus data, open-drain. The block drives only 1'b0 or 1'bz.
- `rd_addr  in  $clog2(NUM_REGS)`: application read index.
- `rd_data  out  8`: `regs[rd_addr]`, combinational.
- `wr_strobe  out  1`: one-cycle pulse per register written over I2C.
- `wr_addr  out  $clog2(NUM_REGS)`: index of the last bus write.
- `wr_data  out  8`: data of the last bus write.
- `busy  out  1`: high from an address match until STOP.

## Operation
- **Input conditioning**
  - SCL and SDA each pass through a 2-flop synchronizer.
  - Rise and fall pulses are derived from the synchronized values.
- **Bus conditions**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Bit transfer**
  - Bits are sampled on the SCL rising pulse, MSB first.
  - The slave changes its SDA drive only on the SCL falling pulse.
- **States**
  - IDLE: waiting for START.
  - ADDR: shift 8 bits (7-bit address, then R/W).
  - ADDR_ACK: on match, drive SDA low for one SCL high period. On mismatch, go to IGNORE.
  - WR_BYTE: shift 8 bits.
  - WR_ACK: always ACK.
    - First byte after the address: load `ptr` with byte mod NUM_REGS; no write occurs.
    - Later bytes: write `regs[ptr]`, pulse `wr_strobe` with `wr_addr`=`ptr` and `wr_data`=byte, then `ptr`++.
  - RD_BYTE: drive `regs[ptr]` MSB first. A 1 bit releases SDA; a 0 bit pulls it low.
  - RD_ACK: release SDA and sample the master's bit.
    - 0 (ACK): `ptr`++ and go to RD_BYTE.
    - 1 (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for STOP or START.
- **Pointer**
  - Wraps from NUM_REGS-1 to 0.
  - Persists across transactions, so a write of pointer only, then repeated START, then read works.
- **STOP** in any state: go to IDLE, release SDA, `busy`=0.
- **START** in any state, including repeated START: go to ADDR with the bit count cleared.
- **Reset values**
  - `sda`=z, `busy`=0, `wr_strobe`=0, `wr_addr`=0, `wr_data`=0, `ptr`=0.
  - All `regs`=0 and state=IDLE.
- **Reset mid-transfer:** SDA is released immediately (asynchronous) and any partial byte is discarded.

## Timing
- Latency from the bus pin to an internal edge pulse: 3 `clk`.
- **ACK/data drive**
  - SDA changes 1 `clk` after the detected SCL falling pulse, i.e. 4 `clk` after the pin.
  - SDA is held until the next falling pulse.
- **Write**
  - `wr_strobe` fires 1 `clk` after the SCL rising pulse of the 8th data bit.
  - `regs` updates on the same edge, so `rd_data` reflects the new value on the following cycle.
- **Simultaneous events**
  - A START/STOP detection overrides bit sampling in the same cycle.
  - An application read concurrent with a bus write returns the old value in that cycle.
- **Ignored traffic:** SCL pulses while in IDLE are ignored; glitches shorter than 2 `clk` may be missed.

## Structure
- Shared package `i2c_pkg`:
  - State encoding, with enumerators shared with the master where names coincide.
  - `I2C_ACK`=1'b0, `I2C_NACK`=1'b1.
  - Address width 7.
- One sub-module, `i2c_sync_edge`:
  - 2-flop synchronizer plus edge detector.
  - Ports: clk, reset, in, level, rise, fall.
  - Instantiated once for SCL and once for SDA; reset value 1 (bus idle high).
- The register file is a plain array inside the top.

## Test plan
- **Single write:** write 0x42+W, ptr 0x03, data 0xA5.
  - ACK on all three bytes.
  - `wr_strobe` fires once with `wr_addr`=3 and `wr_data`=0xA5; `regs[3]`=0xA5.
- **Address mismatch:** address 0x43+W, then 2 bytes.
  - SDA never driven low and `busy` stays 0.
  - No `wr_strobe`; the master sees NACK.
- **Burst write with wrap:** ptr 0x0F, data 0x11 then 0x22.
  - `regs[15]`=0x11 and `regs[0]`=0x22.
- **Combined read:** write ptr 0x03, repeated START, 0x42+R.
  - First byte read is 0xA5.
  - Master ACK then NACK: the second byte read is `regs[4]`, then SDA is released.
- **Reset mid-read:** assert `reset` during RD_BYTE bit 4.
  - SDA goes z within the same cycle and state is IDLE.
  - `ptr`=0 and the next transaction works normally.
- **STOP mid-byte:** STOP after 5 data bits of a write.
  - No write occurs, `busy`=0, and the partial byte is discarded.
